// File: rtl/top_fetch.sv
// Fetch stage: PC register with redirect/stall selection and the fetch/decode
// pipeline register. Instruction memory is read combinationally at PC_F.
module top_fetch #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(32'h0000_0000),
  parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(32'h0000_0013)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_F,
  input  logic             stall_D,
  input  logic             flush_D,
  input  logic             PCsrc_E,
  input  logic [WIDTH-1:0] PCtarget_E,
  input  logic [WIDTH-1:0] imem_data_F,
  output logic [WIDTH-1:0] imem_addr_F,
  output logic [WIDTH-1:0] instr_D,
  output logic [WIDTH-1:0] PC_D,
  output logic [WIDTH-1:0] PCplus4_D,
  output logic             valid_D
);

  logic [WIDTH-1:0] pc_f;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] pc_plus4_f;
  logic [WIDTH-1:0] target_aligned;

  assign pc_plus4_f     = pc_f + WIDTH'(4);
  // Redirect targets are forced to word alignment by clearing the low two bits.
  assign target_aligned = PCtarget_E & ~WIDTH'(3);
  assign imem_addr_F    = pc_f;

  always_comb begin
    pc_next = pc_plus4_f;
    if (PCsrc_E)
      pc_next = target_aligned;
    else if (stall_F)
      pc_next = pc_f;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pc_f <= RESET_PC;
    else
      pc_f <= pc_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_D   <= NOP_INSTR;
      PC_D      <= '0;
      PCplus4_D <= '0;
      valid_D   <= 1'b0;
    end else if (flush_D) begin
      instr_D   <= NOP_INSTR;
      PC_D      <= '0;
      PCplus4_D <= '0;
      valid_D   <= 1'b0;
    end else if (!stall_D) begin
      instr_D   <= imem_data_F;
      PC_D      <= pc_f;
      PCplus4_D <= pc_plus4_f;
      valid_D   <= 1'b1;
    end
  end

endmodule
